// File: rtl/fp_norm_round_pack.sv
// fp_norm_round_pack: back end of the FP MAC datapath.
// Stage 1 captures the adder sum and counts leading zeros, stage 2 normalises
// and adjusts the exponent, stage 3 rounds to nearest-even and packs an
// IEEE-754 single-precision result. A global hold freezes every register.
module fp_norm_round_pack #(
    parameter int MAG_W = 25,
    parameter int EXP_W = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   in_valid,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAG_W-1:0]       in_mag,
    input  logic [1:0]             in_rs,
    input  logic                   hold,
    output logic                   out_valid,
    output logic [EXP_W+MAG_W-2:0] out_result,
    output logic                   out_zero,
    output logic                   out_ovf,
    output logic                   out_uf
);

    localparam int MANT_W = MAG_W - 1;          // mantissa incl. hidden one
    localparam int FRAC_W = MAG_W - 2;          // stored fraction
    localparam int E_W    = EXP_W + 2;          // exponent with sign + headroom
    localparam int LZ_W   = $clog2(MANT_W + 1);
    localparam logic [E_W-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    // Stage 1 registers
    logic                 s1_valid_q;
    logic                 s1_sign_q;
    logic [EXP_W-1:0]     s1_exp_q;
    logic [MAG_W-1:0]     s1_mag_q;
    logic [1:0]           s1_rs_q;
    logic [LZ_W-1:0]      s1_lz_q;
    logic [LZ_W-1:0]      s1_lz_d;

    // Stage 2 registers
    logic                 s2_valid_q;
    logic                 s2_sign_q,  s2_sign_d;
    logic [MANT_W-1:0]    s2_mant_q,  s2_mant_d;
    logic                 s2_r_q,     s2_r_d;
    logic                 s2_s_q,     s2_s_d;
    logic [E_W-1:0]       s2_exp_q,   s2_exp_d;
    logic                 s2_zero_q,  s2_zero_d;
    logic                 s2_uf_q,    s2_uf_d;
    logic [MAG_W-1:0]     s2_shifted;

    // Stage 3 (output) registers
    logic                 out_valid_q;
    logic [EXP_W+FRAC_W:0] out_result_q, s3_result_d;
    logic                 out_zero_q, s3_zero_d;
    logic                 out_ovf_q,  s3_ovf_d;
    logic                 out_uf_q,   s3_uf_d;
    logic                 s3_inc;
    logic [MANT_W:0]      s3_round;
    logic [E_W-1:0]       s3_exp;
    logic [FRAC_W-1:0]    s3_frac;

    // Leading-zero count of mag[23:0]; the highest set bit wins
    always_comb begin
        s1_lz_d = LZ_W'(MANT_W);
        for (int unsigned i = 0; i < MANT_W; i++) begin
            if (in_mag[i]) s1_lz_d = LZ_W'(MANT_W - 1 - i);
        end
    end

    // Normalise: right shift on carry-out, else left shift by the zero count
    always_comb begin
        s2_sign_d  = s1_sign_q;
        s2_mant_d  = '0;
        s2_r_d     = 1'b0;
        s2_s_d     = 1'b0;
        s2_exp_d   = '0;
        s2_zero_d  = 1'b0;
        s2_uf_d    = 1'b0;
        s2_shifted = '0;
        if (s1_mag_q == '0) begin
            s2_sign_d = 1'b0;
            s2_zero_d = 1'b1;
        end else if (s1_exp_q == '0) begin
            s2_zero_d = 1'b1;
            s2_uf_d   = 1'b1;
        end else if (s1_mag_q[MAG_W-1]) begin
            s2_mant_d = s1_mag_q[MAG_W-1:1];
            s2_r_d    = s1_mag_q[0];
            s2_s_d    = s1_rs_q[1] | s1_rs_q[0];
            s2_exp_d  = E_W'(s1_exp_q) + E_W'(1);
        end else begin
            // round bit travels up with the mantissa; sticky stays below
            s2_shifted = {s1_mag_q[MANT_W-1:0], s1_rs_q[1]} << s1_lz_q;
            s2_mant_d  = s2_shifted[MANT_W:1];
            s2_r_d     = s2_shifted[0];
            s2_s_d     = s1_rs_q[0];
            s2_exp_d   = E_W'(s1_exp_q) - E_W'(s1_lz_q);
            if (s2_exp_d[E_W-1] || (s2_exp_d == '0)) begin
                s2_zero_d = 1'b1;
                s2_uf_d   = 1'b1;
            end
        end
    end

    // Round to nearest-even, handle mantissa carry, overflow and packing
    always_comb begin
        s3_inc      = s2_r_q & (s2_s_q | s2_mant_q[0]);
        s3_round    = {1'b0, s2_mant_q} + {{MANT_W{1'b0}}, s3_inc};
        s3_exp      = s2_exp_q + {{(E_W-1){1'b0}}, s3_round[MANT_W]};
        // on carry the mantissa is 1.0, so bits MANT_W-1:1 are all zero
        s3_frac     = s3_round[MANT_W] ? s3_round[MANT_W-1:1] : s3_round[FRAC_W-1:0];
        s3_result_d = {s2_sign_q, s3_exp[EXP_W-1:0], s3_frac};
        s3_zero_d   = 1'b0;
        s3_ovf_d    = 1'b0;
        s3_uf_d     = 1'b0;
        if (s2_zero_q) begin
            s3_result_d = {s2_sign_q, {(EXP_W+FRAC_W){1'b0}}};
            s3_zero_d   = 1'b1;
            s3_uf_d     = s2_uf_q;
        end else if (s3_exp >= EXP_MAX) begin
            s3_result_d = {s2_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            s3_ovf_d    = 1'b1;
        end
    end

    // Pipeline registers: reset clears everything, hold freezes every stage
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_mag_q     <= '0;
            s1_rs_q      <= '0;
            s1_lz_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_mant_q    <= '0;
            s2_r_q       <= 1'b0;
            s2_s_q       <= 1'b0;
            s2_exp_q     <= '0;
            s2_zero_q    <= 1'b0;
            s2_uf_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_uf_q     <= 1'b0;
        end else if (!hold) begin
            s1_valid_q   <= in_valid;
            s1_sign_q    <= in_sign;
            s1_exp_q     <= in_exp;
            s1_mag_q     <= in_mag;
            s1_rs_q      <= in_rs;
            s1_lz_q      <= s1_lz_d;
            s2_valid_q   <= s1_valid_q;
            s2_sign_q    <= s2_sign_d;
            s2_mant_q    <= s2_mant_d;
            s2_r_q       <= s2_r_d;
            s2_s_q       <= s2_s_d;
            s2_exp_q     <= s2_exp_d;
            s2_zero_q    <= s2_zero_d;
            s2_uf_q      <= s2_uf_d;
            out_valid_q  <= s2_valid_q;
            if (s2_valid_q) begin
                out_result_q <= s3_result_d;
                out_zero_q   <= s3_zero_d;
                out_ovf_q    <= s3_ovf_d;
                out_uf_q     <= s3_uf_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;
    assign out_ovf    = out_ovf_q;
    assign out_uf     = out_uf_q;

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Testbench for fp_norm_round_pack: directed vectors, latency, hold, reset
// and randomized beats checked against an arithmetic reference model.
module tb_fp_norm_round_pack;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mag;
    logic [1:0]  in_rs;
    logic        hold;
    logic        out_valid;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ovf;
    logic        out_uf;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        uf;
    } res_t;

    typedef struct {
        bit        sign;
        bit [7:0]  exp;
        bit [24:0] mag;
        bit [1:0]  rs;
        res_t      want;
    } vec_t;

    int   checks     = 0;
    int   failures   = 0;
    int   valid_seen = 0;
    res_t exp_q[$];

    fp_norm_round_pack #(.MAG_W(25), .EXP_W(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mag     (in_mag),
        .in_rs      (in_rs),
        .hold       (hold),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .out_uf     (out_uf)
    );

    always #5 clock = ~clock;

    // Reference: value = mag * 2^(exp-127-23) with round/sticky tail below
    function automatic res_t model(input bit sg, input int e_in, input int mag,
                                   input int r, input int s);
        res_t o;
        int   p, m2, e, mant, rb, sb;
        o = '0;
        if (mag == 0) begin
            o.zero = 1'b1;
            return o;
        end
        if (e_in == 0) begin
            o.res  = {sg, 31'h0};
            o.zero = 1'b1;
            o.uf   = 1'b1;
            return o;
        end
        p = 24;
        while (mag < (1 << p)) p--;
        if (p == 24) begin
            mant = mag / 2;
            rb   = mag % 2;
            sb   = r | s;
            e    = e_in + 1;
        end else begin
            m2   = (mag * 2 + r) * (1 << (23 - p));
            mant = m2 / 2;
            rb   = m2 % 2;
            sb   = s;
            e    = e_in - (23 - p);
        end
        if (e <= 0) begin
            o.res  = {sg, 31'h0};
            o.zero = 1'b1;
            o.uf   = 1'b1;
            return o;
        end
        if (rb == 1 && (sb == 1 || (mant % 2) == 1)) mant = mant + 1;
        if (mant == (1 << 24)) begin
            mant = 1 << 23;
            e    = e + 1;
        end
        if (e >= 255) begin
            o.res = {sg, 8'hFF, 23'h0};
            o.ovf = 1'b1;
            return o;
        end
        o.res = {sg, 8'(e), 23'(mant)};
        return o;
    endfunction

    function automatic vec_t mkv(input bit sg, input bit [7:0] e, input bit [24:0] m,
                                 input bit [1:0] rs, input bit [31:0] res,
                                 input bit z, input bit ov, input bit u);
        vec_t v;
        v.sign = sg; v.exp = e; v.mag = m; v.rs = rs;
        v.want = {res, z, ov, u};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input bit v, input bit h, input bit sg, input bit [7:0] e,
                         input bit [24:0] m, input bit [1:0] rs, input res_t want);
        @(negedge clock);
        in_valid = v; hold = h; in_sign = sg; in_exp = e; in_mag = m; in_rs = rs;
        if (v && !h && resetn) exp_q.push_back(want);
    endtask

    task automatic idle(input bit h);
        drive(1'b0, h, 1'b0, 8'h00, 25'h0, 2'b00, '0);
    endtask

    task automatic rand_beat(input bit v, input bit h);
        bit        sg;
        bit [7:0]  e;
        bit [24:0] m;
        bit [1:0]  rs;
        sg = 1'($urandom);
        case ($urandom % 8)
            0: e = 8'd0;
            1: e = 8'd255;
            2: e = 8'd254;
            3: e = 8'($urandom_range(1, 30));
            default: e = 8'($urandom);
        endcase
        case ($urandom % 8)
            0: m = 25'h0;
            1: m = 25'h1FFFFFF;
            2: m = 25'h1 << ($urandom % 25);
            3: m = 25'($urandom) | 25'h1000000;
            default: m = 25'($urandom) >> ($urandom % 25);
        endcase
        rs = 2'($urandom);
        drive(v, h, sg, e, m, rs, model(sg, int'(e), int'(m), int'(rs[1]), int'(rs[0])));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b0);
        idle(1'b0);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: looks at each edge's control inputs, checks outputs just after
    initial begin : monitor
        bit   e_rst, e_hold, snap_v;
        res_t snap, got, want;
        forever begin
            @(posedge clock);
            e_rst  = resetn;
            e_hold = hold;
            snap_v = out_valid;
            snap   = {out_result, out_zero, out_ovf, out_uf};
            #1;
            got = {out_result, out_zero, out_ovf, out_uf};
            if (!e_rst) begin
                check("reset_outputs", {28'h0, out_valid, got}, 64'h0);
                exp_q.delete();
            end else if (e_hold) begin
                check("hold_frozen", {28'h0, out_valid, got}, {28'h0, snap_v, snap});
            end else if (out_valid) begin
                valid_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    want = exp_q.pop_front();
                    check("beat_result", 64'(got), 64'(want));
                end
            end else begin
                check("bubble_keeps", 64'(got), 64'(snap));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin : main
        vec_t tbl[17];
        int   lat, base;
        tbl[0]  = mkv(0, 127, 25'h0800000, 2'b00, 32'h3F800000, 0, 0, 0);
        tbl[1]  = mkv(0, 127, 25'h1000000, 2'b00, 32'h40000000, 0, 0, 0);
        tbl[2]  = mkv(0, 127, 25'h0000001, 2'b00, 32'h34000000, 0, 0, 0);
        tbl[3]  = mkv(0, 127, 25'h1FFFFFF, 2'b00, 32'h40800000, 0, 0, 0);
        tbl[4]  = mkv(1, 254, 25'h1000000, 2'b00, 32'hFF800000, 0, 1, 0);
        tbl[5]  = mkv(0,   3, 25'h0000010, 2'b00, 32'h00000000, 1, 0, 1);
        tbl[6]  = mkv(1, 100, 25'h0000000, 2'b11, 32'h00000000, 1, 0, 0);
        tbl[7]  = mkv(1,   0, 25'h0800000, 2'b00, 32'h80000000, 1, 0, 1);
        tbl[8]  = mkv(0, 127, 25'h1000001, 2'b00, 32'h40000000, 0, 0, 0);
        tbl[9]  = mkv(0, 127, 25'h1000003, 2'b00, 32'h40000002, 0, 0, 0);
        tbl[10] = mkv(0, 255, 25'h0800000, 2'b00, 32'h7F800000, 0, 1, 0);
        tbl[11] = mkv(0, 127, 25'h0400000, 2'b10, 32'h3F000001, 0, 0, 0);
        tbl[12] = mkv(0, 127, 25'h0800000, 2'b11, 32'h3F800001, 0, 0, 0);
        tbl[13] = mkv(0, 127, 25'h0800000, 2'b10, 32'h3F800000, 0, 0, 0);
        tbl[14] = mkv(0, 254, 25'h0FFFFFF, 2'b10, 32'h7F800000, 0, 1, 0);
        tbl[15] = mkv(0,   1, 25'h0400000, 2'b00, 32'h00000000, 1, 0, 1);
        tbl[16] = mkv(1,   0, 25'h1000000, 2'b00, 32'h80000000, 1, 0, 1);

        resetn = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0;
        in_mag = '0; in_rs = '0; hold = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_state", {28'h0, out_valid, out_result, out_zero, out_ovf, out_uf}, 64'h0);
        resetn = 1'b1;
        idle(1'b0);

        // latency: beat sampled at the next edge, visible after the third edge
        drive(1, 0, tbl[0].sign, tbl[0].exp, tbl[0].mag, tbl[0].rs, tbl[0].want);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (out_valid) begin
                lat = i;
                break;
            end
            in_valid = 1'b0;
        end
        check("latency", 64'(lat), 64'd3);
        drain("drain_latency");

        // directed vectors, back to back
        for (int i = 0; i < 17; i++)
            drive(1, 0, tbl[i].sign, tbl[i].exp, tbl[i].mag, tbl[i].rs, tbl[i].want);
        drain("drain_table");

        // four beats with a two-cycle hold in the middle; in_* ignored while held
        base = valid_seen;
        drive(1, 0, tbl[0].sign, tbl[0].exp, tbl[0].mag, tbl[0].rs, tbl[0].want);
        drive(1, 0, tbl[1].sign, tbl[1].exp, tbl[1].mag, tbl[1].rs, tbl[1].want);
        drive(1, 1, tbl[4].sign, tbl[4].exp, tbl[4].mag, tbl[4].rs, '0);
        drive(1, 1, tbl[5].sign, tbl[5].exp, tbl[5].mag, tbl[5].rs, '0);
        drive(1, 0, tbl[2].sign, tbl[2].exp, tbl[2].mag, tbl[2].rs, tbl[2].want);
        drive(1, 0, tbl[3].sign, tbl[3].exp, tbl[3].mag, tbl[3].rs, tbl[3].want);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        drain("drain_hold");
        check("hold_beat_count", 64'(valid_seen - base), 64'd4);

        // reset with two beats in flight, hold asserted (reset has priority)
        drive(1, 0, tbl[9].sign, tbl[9].exp, tbl[9].mag, tbl[9].rs, tbl[9].want);
        drive(1, 0, tbl[4].sign, tbl[4].exp, tbl[4].mag, tbl[4].rs, tbl[4].want);
        @(negedge clock);
        resetn = 1'b0; hold = 1'b1; in_valid = 1'b1;
        @(negedge clock);
        resetn = 1'b1; hold = 1'b0; in_valid = 1'b0;
        base = valid_seen;
        repeat (6) idle(1'b0);
        check("no_stale_after_reset", 64'(valid_seen - base), 64'd0);

        // randomized beats with bubbles and holds
        for (int i = 0; i < 400; i++)
            rand_beat(($urandom % 5) != 0, ($urandom % 10) == 0);
        drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
